display_sequencer: RTL

// - Parametrised per-pixel colour generator; successor to the fixed 14-mode display block.
// - Consumes timing from the VGA timing generator and the music engine's phrase/crotchet strobes.
// - Steps through NUM_MODES animated patterns and drives registered colour plus aligned sync/blank.
// - Adds XOR patterns, a configurable shift schedule and an optional beat-synchronised inversion flash.

---
 rtl/display_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/display_sequencer.sv
// Per-pixel colour generator: steps through NUM_MODES animated XOR/sum patterns.
// Optional beat-synchronised inversion flash is built when CROTCHET_FLASH_EN is defined.
module display_sequencer #(
    parameter int COLOUR_W     = 6,
    parameter int POS_W        = 10,
    parameter int FRAME_W      = 10,
    parameter int NUM_MODES    = 14,
    parameter int SHIFT2_BELOW = 4,
    parameter int SHIFT1_BELOW = 10,
    parameter int MODE0_COLOUR = 1,
    parameter int FLASH_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [POS_W-1:0]    x_pos,
    input  logic [POS_W-1:0]    y_pos,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                blank_in,
    input  logic                next_frame,
    input  logic                phrase,
    input  logic                crotchet,
    output logic                hsync,
    output logic                vsync,
    output logic                blank,
    output logic [COLOUR_W-1:0] colour,
    output logic [3:0]          mode
);

    localparam int AW = ((POS_W > FRAME_W) ? POS_W : FRAME_W) + 1;

    logic [3:0]          r_mode;
    logic [FRAME_W-1:0]  r_frame;
    logic [1:0]          w_shift;
    logic [FRAME_W-1:0]  w_f;
    logic [AW-1:0]       w_x;
    logic [AW-1:0]       w_y;
    logic [AW-1:0]       w_fw;
    logic [AW-1:0]       w_sum;
    logic [COLOUR_W-1:0] w_pattern;
    logic                w_flash_active;

    // Phrase has priority: it resets the frame even when next_frame coincides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= '0;
            r_frame <= '0;
        end else if (phrase) begin
            r_frame <= '0;
            r_mode  <= (r_mode == 4'(NUM_MODES - 1)) ? 4'd0 : r_mode + 4'd1;
        end else if (next_frame) begin
            r_frame <= r_frame + 1'b1;
        end
    end

    always_comb begin
        w_shift = 2'd0;
        if (32'(r_mode) < SHIFT2_BELOW)
            w_shift = 2'd2;
        else if (32'(r_mode) < SHIFT1_BELOW)
            w_shift = 2'd1;
    end

    assign w_f  = r_frame >> w_shift;
    assign w_x  = AW'(x_pos);
    assign w_y  = AW'(y_pos);
    assign w_fw = AW'(w_f);

    always_comb begin
        if (r_mode[0])
            w_sum = (w_x ^ w_y) + w_fw;
        else
            w_sum = w_x + w_y + w_fw;
    end

    assign w_pattern = (r_mode == 4'd0) ? COLOUR_W'(MODE0_COLOUR) : COLOUR_W'(w_sum);

`ifdef CROTCHET_FLASH_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLASH = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_flash_cnt;

    // A crotchet reload wins over a same-cycle next_frame decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_flash_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (crotchet) begin
                r_state     <= ST_FLASH;
                r_flash_cnt <= 8'(FLASH_FRAMES);
            end
        end else begin
            if (crotchet) begin
                r_flash_cnt <= 8'(FLASH_FRAMES);
            end else if (next_frame) begin
                r_flash_cnt <= r_flash_cnt - 8'd1;
                if (r_flash_cnt == 8'd1)
                    r_state <= ST_IDLE;
            end
        end
    end

    assign w_flash_active = (r_state == ST_FLASH) && (r_mode != 4'd0);
`else
    logic w_unused_crotchet;
    assign w_unused_crotchet = crotchet;
    assign w_flash_active    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour <= '0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            blank  <= 1'b1;
        end else begin
            hsync <= hsync_in;
            vsync <= vsync_in;
            blank <= blank_in;
            if (blank_in)
                colour <= '0;
            else if (w_flash_active)
                colour <= ~w_pattern;
            else
                colour <= w_pattern;
        end
    end

    assign mode = r_mode;

endmodule
